// File: rtl/add_arb_pkg.sv
// Shared types and default sizing for the arbitrated adder.
// Optional feature macro: ADD_ARB_OVF_EN (signed overflow flag on the response).
package add_arb_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_NREQ  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/add_arb_if.sv
// Request/response bundle between requesters and the arbitrated adder.
// Optional feature macro: ADD_ARB_OVF_EN adds rsp_ovf.
interface add_arb_if #(
  parameter int WIDTH = add_arb_pkg::DEF_WIDTH,
  parameter int NREQ  = add_arb_pkg::DEF_NREQ
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_cin;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_sum;
  logic                  rsp_cout;
`ifdef ADD_ARB_OVF_EN
  logic                  rsp_ovf;
`endif
  logic                  busy;

  modport master (
    output req_valid, req_a, req_b, req_cin, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout,
`ifdef ADD_ARB_OVF_EN
           rsp_ovf,
`endif
           busy
  );

  modport slave (
    input  req_valid, req_a, req_b, req_cin, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout,
`ifdef ADD_ARB_OVF_EN
           rsp_ovf,
`endif
           busy
  );

endinterface

// File: rtl/add_arb_rr_arbiter.sv
// Round-robin arbiter: search starts one past last_grant, first active request wins.
// Purely combinational; the owner of last_grant decides when a grant is taken.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last_grant,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx,
  output logic            any_grant
);

  int idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_grant) + k) % NREQ;
      if (!any_grant && req[idx]) begin
        any_grant  = 1'b1;
        grant_idx  = IDW'(idx);
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/add_arb.sv
// Shared adder serving NREQ requesters, one operation in flight at a time.
// Optional feature macro: ADD_ARB_OVF_EN registers a signed overflow flag with the sum.
//
// state | meaning
// IDLE  | arbitrate; winner sees req_ready this cycle and its operands are captured
// EXEC  | adder evaluates captured operands; result registered
// RESP  | response held on the bus until rsp_ready
module add_arb
  import add_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ  = DEF_NREQ
) (
  input logic     clk,
  input logic     rst,
  add_arb_if.slave bus
);

  localparam int IDW = $clog2(NREQ);

  state_t            state;
  logic [IDW-1:0]    last_grant;
  logic [NREQ-1:0]   grant;
  logic [IDW-1:0]    grant_idx;
  logic              any_grant;

  logic [WIDTH-1:0]  a_lane [NREQ];
  logic [WIDTH-1:0]  b_lane [NREQ];
  logic [WIDTH-1:0]  cap_a;
  logic [WIDTH-1:0]  cap_b;
  logic              cap_cin;
  logic [IDW-1:0]    cap_id;
  logic [WIDTH:0]    sum_full;

  logic              rsp_valid_q;
  logic [IDW-1:0]    rsp_id_q;
  logic [WIDTH-1:0]  rsp_sum_q;
  logic              rsp_cout_q;

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    assign a_lane[i] = bus.req_a[i*WIDTH +: WIDTH];
    assign b_lane[i] = bus.req_b[i*WIDTH +: WIDTH];
  end

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_arbiter (
    .req        (bus.req_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .any_grant  (any_grant)
  );

  // The grant is offered combinationally so a requester is accepted in the cycle it wins.
  assign bus.req_ready = (state == IDLE && !rst) ? grant : '0;

  assign sum_full = {1'b0, cap_a} + {1'b0, cap_b} + {{WIDTH{1'b0}}, cap_cin};

`ifdef ADD_ARB_OVF_EN
  logic msb_carry_in;
  logic rsp_ovf_q;

  assign msb_carry_in = cap_a[WIDTH-1] ^ cap_b[WIDTH-1] ^ sum_full[WIDTH-1];
  assign bus.rsp_ovf  = rsp_ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_ovf_q <= 1'b0;
    end else if (state == EXEC) begin
      rsp_ovf_q <= msb_carry_in ^ sum_full[WIDTH];
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= IDW'(NREQ - 1);
      cap_a       <= '0;
      cap_b       <= '0;
      cap_cin     <= 1'b0;
      cap_id      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_grant) begin
            cap_a      <= a_lane[grant_idx];
            cap_b      <= b_lane[grant_idx];
            cap_cin    <= bus.req_cin[grant_idx];
            cap_id     <= grant_idx;
            last_grant <= grant_idx;
            state      <= EXEC;
          end
        end
        EXEC: begin
          rsp_sum_q   <= sum_full[WIDTH-1:0];
          rsp_cout_q  <= sum_full[WIDTH];
          rsp_id_q    <= cap_id;
          rsp_valid_q <= 1'b1;
          state       <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_cout  = rsp_cout_q;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_add_arb.sv
// Directed bench for add_arb: vector table of single operations plus fairness,
// backpressure and reset-in-flight sequences. Overflow checks need ADD_ARB_OVF_EN.
module tb_add_arb;
  import add_arb_pkg::*;

  localparam int W = 16;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  add_arb_if #(.WIDTH(W), .NREQ(N)) bus ();

  add_arb #(.WIDTH(W), .NREQ(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          id;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs [8];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_lane(input int i, input logic [15:0] a, input logic [15:0] b, input logic c);
    bus.req_a[i*W +: W] = a;
    bus.req_b[i*W +: W] = b;
    bus.req_cin[i]      = c;
  endtask

  task automatic scramble();
    for (int i = 0; i < N; i++) set_lane(i, 16'hDEAD, 16'hBEEF, 1'b1);
  endtask

  // Waits (bounded) for a response, checks it, then completes the handshake.
  task automatic wait_rsp(input string tag, input int exp_id, input logic [15:0] exp_sum);
    for (int k = 0; k < 10; k++) begin
      if (bus.rsp_valid === 1'b1) break;
      @(negedge clk); #1;
    end
    check({tag, "_valid"}, 32'(bus.rsp_valid), 32'd1);
    check({tag, "_id"},    32'(bus.rsp_id),    32'(exp_id));
    check({tag, "_sum"},   32'(bus.rsp_sum),   32'(exp_sum));
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq [6];
    int got;
    int last_cyc;

    vecs[0] = '{2, 16'h1234, 16'h0FF0, 1'b1, 16'h2225, 1'b0, 1'b0};
    vecs[1] = '{0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[2] = '{1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[3] = '{3, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[4] = '{1, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[5] = '{0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[6] = '{3, 16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0, 1'b0};
    vecs[7] = '{2, 16'h7FFF, 16'h7FFF, 1'b1, 16'hFFFF, 1'b0, 1'b1};
    seq = '{0, 1, 2, 3, 0, 1};

    // Reset with every requester asking: nothing may be accepted.
    rst           = 1'b1;
    bus.req_valid = '1;
    bus.rsp_ready = 1'b0;
    scramble();
    @(negedge clk);
    @(negedge clk); #1;
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_id",    32'(bus.rsp_id),    32'd0);
    check("rst_rsp_sum",   32'(bus.rsp_sum),   32'd0);
    check("rst_rsp_cout",  32'(bus.rsp_cout),  32'd0);
    check("rst_busy",      32'(bus.busy),      32'd0);
`ifdef ADD_ARB_OVF_EN
    check("rst_rsp_ovf",   32'(bus.rsp_ovf),   32'd0);
`endif
    bus.req_valid = '0;
    rst           = 1'b0;
    @(negedge clk); #1;
    check("idle_no_req_ready", 32'(bus.req_ready), 32'd0);

    for (int v = 0; v < 8; v++) begin
      scramble();
      set_lane(vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].cin);
      bus.req_valid = 4'(1 << vecs[v].id);
      #1;
      check("vec_ready", 32'(bus.req_ready), 32'(1 << vecs[v].id));
      @(negedge clk);
      bus.req_valid = '0;
      scramble();
      #1;
      check("vec_exec_valid", 32'(bus.rsp_valid), 32'd0);
      check("vec_exec_busy",  32'(bus.busy),      32'd1);
      check("vec_exec_ready", 32'(bus.req_ready), 32'd0);
      @(negedge clk); #1;
      check("vec_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("vec_rsp_id",    32'(bus.rsp_id),    32'(vecs[v].id));
      check("vec_rsp_sum",   32'(bus.rsp_sum),   32'(vecs[v].sum));
      check("vec_rsp_cout",  32'(bus.rsp_cout),  32'(vecs[v].cout));
`ifdef ADD_ARB_OVF_EN
      check("vec_rsp_ovf",   32'(bus.rsp_ovf),   32'(vecs[v].ovf));
`endif
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      #1;
      check("vec_done_valid", 32'(bus.rsp_valid), 32'd0);
      check("vec_done_busy",  32'(bus.busy),      32'd0);
    end

    // Fairness: all requesters held high from reset.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N; i++) set_lane(i, 16'(i * 256), 16'h0001, 1'b0);
    bus.req_valid = '1;
    bus.rsp_ready = 1'b1;
    got      = 0;
    last_cyc = 0;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      @(negedge clk); #1;
      if (bus.rsp_valid === 1'b1) begin
        check("fair_id",  32'(bus.rsp_id),  32'(seq[got]));
        check("fair_sum", 32'(bus.rsp_sum), 32'(seq[got] * 256 + 1));
        if (got > 0) check("fair_gap", 32'(cyc - last_cyc), 32'd3);
        last_cyc = cyc;
        got++;
      end
    end
    check("fair_count", 32'(got), 32'd6);
    bus.req_valid = '0;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    #1;
    check("fair_idle", 32'(bus.busy), 32'd0);

    // Backpressure: response held for several cycles while others wait.
    scramble();
    set_lane(1, 16'h0101, 16'h0202, 1'b0);
    bus.req_valid = 4'b0010;
    #1;
    check("bp_ready", 32'(bus.req_ready), 32'b0010);
    @(negedge clk);
    set_lane(0, 16'h0F00, 16'h0001, 1'b0);
    set_lane(1, 16'hDEAD, 16'hBEEF, 1'b1);
    set_lane(3, 16'h1000, 16'h0234, 1'b1);
    bus.req_valid = 4'b1001;
    @(negedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      check("bp_hold_valid", 32'(bus.rsp_valid), 32'd1);
      check("bp_hold_id",    32'(bus.rsp_id),    32'd1);
      check("bp_hold_sum",   32'(bus.rsp_sum),   32'h0303);
      check("bp_hold_ready", 32'(bus.req_ready), 32'd0);
      @(negedge clk); #1;
    end
    check("bp_still_valid", 32'(bus.rsp_valid), 32'd1);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    #1;
    check("bp_release_valid", 32'(bus.rsp_valid), 32'd0);
    check("bp_release_busy",  32'(bus.busy),      32'd0);
    check("bp_next_grant",    32'(bus.req_ready), 32'b1000);
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    wait_rsp("bp_next", 3, 16'h1235);

    // Reset while the grant is in EXEC: that result must never appear.
    set_lane(2, 16'h1111, 16'h2222, 1'b0);
    bus.req_valid = 4'b0100;
    #1;
    check("rx_ready", 32'(bus.req_ready), 32'b0100);
    @(negedge clk);
    bus.req_valid = '0;
    rst           = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("rx_no_rsp", 32'(bus.rsp_valid), 32'd0);
      @(negedge clk);
    end
    #1;
    check("rx_sum_cleared", 32'(bus.rsp_sum), 32'd0);
    set_lane(0, 16'h0005, 16'h0003, 1'b0);
    bus.req_valid = 4'b0101;
    #1;
    check("rx_first_grant", 32'(bus.req_ready), 32'b0001);
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    wait_rsp("rx_after", 0, 16'h0008);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
